vec_alu_sequencer: RTL and testbench
====================================

Name: vec_alu_sequencer

Overview:
- Sequences vector instructions (VADD, VDOT, SMUL) lane by lane through one shared scalar FP16 functional unit (FU), then assembles the 256-bit vector result.
- Sits between the decode/issue stage and the scalar FP16 add/multiply unit.
- Keeps one scalar adder/multiplier in silicon instead of 16 parallel lanes.
- Accepts one instruction at a time and returns one result per instruction.

Parameters:
- LANES, 16, number of vector lanes.
- LANE_W, 16, lane width in bits (FP16: sign[15], exp[14:10], mantissa[9:0]).
- VEC_W, LANES*LANE_W (256), vector width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  instruction offered.
- in_ready  out  1  sequencer can accept an instruction.
- opcode  in  4  0000 VADD, 0001 VDOT, 0010 SMUL, 1111 NOP; every other value is unsupported.
- op_1  in  VEC_W  first operand. SMUL uses op_1[15:0] as the scalar.
- op_2  in  VEC_W  second operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  VEC_W  vector result.
- err  out  1  unsupported opcode; valid while out_valid=1.
- fu_req  out  1  FU operation requested.
- fu_op  out  1  0 = add, 1 = multiply.
- fu_a  out  LANE_W  FU operand A.
- fu_b  out  LANE_W  FU operand B.
- fu_ack  in  1  FU operation complete; consumes the current request.
- fu_result  in  LANE_W  FU result; valid when fu_ack=1.

Behaviour:
- Reset values (asynchronous, while rst_n=0): state=IDLE, in_ready=1, out_valid=0, err=0, fu_req=0, fu_op=0, fu_a=0, fu_b=0, result=0, lane counter=0, accumulator=0.
- States: IDLE, REQ, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch opcode, op_1 and op_2, and clear the result register.
  - Supported vector opcode -> REQ, lane=0, phase=MUL.
  - NOP -> DONE with result=0, err=0.
  - Unsupported opcode -> DONE with result=0, err=1.
- REQ:
  - in_ready=0 and fu_req=1 throughout the state.
  - fu_op, fu_a and fu_b stay stable until fu_ack is sampled high.
  - Each edge with fu_ack=1 completes exactly one FU transaction.
  - The next operation's operands are presented in the following cycle, and fu_req may remain high across transactions.
- VADD: lane i issues add(op_1 lane i, op_2 lane i). The ack writes result lane i. After lane LANES-1 is acked -> DONE. Total 16 transactions.
- SMUL: lane i issues mul(op_1[15:0], op_2 lane i). The ack writes result lane i. Total 16 transactions.
- VDOT, 31 transactions:
  - Lane 0: mul(a0, b0); the ack loads the accumulator directly.
  - Lanes 1..15, MUL phase: mul(ai, bi); the ack stores the product in a temp register, phase=ACC.
  - Lanes 1..15, ACC phase: add(acc, temp); the ack updates the accumulator, phase=MUL, lane increments.
  - After the ACC ack for lane 15: result[15:0]=acc, all other lanes 0 -> DONE.
- Lane counter is 4 bits. Completion is detected at lane==LANES-1 together with the ack, never by wrap-around.
- DONE:
  - out_valid=1; result and err are held stable.
  - On out_ready=1 -> IDLE: out_valid=0, err=0, in_ready=1 the next cycle.
  - No instruction is accepted in the same cycle as out_ready; minimum one IDLE cycle between instructions.
- Latency, accept edge to out_valid:
  - NOP/unsupported: 1 cycle.
  - Vector ops: 1 + sum of FU transaction latencies. With an FU that acks one cycle after request, VADD/SMUL = 1 + 16 cycles.
- fu_ack outside REQ is ignored.
- in_valid while in_ready=0 is ignored; the upstream stage holds it.
- No FP arithmetic occurs in this block; NaN/Inf/denormal handling belongs to the FU.
- Reset mid-operation abandons the instruction. fu_req drops immediately and no result is produced.

Test Plan:
- VADD, op_1 = op_2 = all lanes 16'h3C00; FU model acks 1 cycle after request -> 16 fu_req/fu_ack pairs, fu_op=0 each; result = all lanes 16'h4000; err=0; out_valid 17 cycles after accept.
- VDOT, op_1 = op_2 = all lanes 16'h3C00 -> 31 transactions (16 mul, 15 add, alternating after lane 0); result[15:0]=16'h4C00 (16.0); result[255:16]=0.
- SMUL, op_1[15:0]=16'h4000, op_1 upper lanes=16'hFFFF, op_2 lanes=16'h3C00 -> every fu_a=16'h4000, fu_op=1; result all lanes 16'h4000 (upper op_1 lanes unused).
- NOP then opcode 4'b0110 -> each gives out_valid 1 cycle after accept, result=0, zero FU transactions; err=0 for NOP, err=1 for 0110.
- Backpressure: VADD completes with out_ready=0 for 5 cycles -> out_valid, result and err stable; in_ready=0 while in_valid stays high; accepted only after the out_ready handshake plus one IDLE cycle.
- Randomised FU ack latency 1-6 cycles on VDOT -> identical result; rst_n pulsed low during lane 7 -> fu_req=0 and out_valid=0 immediately, in_ready=1; the next VADD completes correctly.

Source files
------------

// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: steps VADD / VDOT / SMUL lane by lane through one shared
// scalar FP16 functional unit and assembles the 256-bit vector result.
module vec_alu_sequencer #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned VEC_W  = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [VEC_W-1:0]  op_1,
  input  logic [VEC_W-1:0]  op_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  result,
  output logic              err,
  output logic              fu_req,
  output logic              fu_op,
  output logic [LANE_W-1:0] fu_a,
  output logic [LANE_W-1:0] fu_b,
  input  logic              fu_ack,
  input  logic [LANE_W-1:0] fu_result
);

  localparam int unsigned LaneBits = $clog2(LANES);
  localparam logic [LaneBits-1:0] LastLane = LaneBits'(LANES - 1);

  localparam logic [3:0] OpVadd = 4'b0000;
  localparam logic [3:0] OpVdot = 4'b0001;
  localparam logic [3:0] OpSmul = 4'b0010;
  localparam logic [3:0] OpNop  = 4'b1111;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
  typedef enum logic {PhMul, PhAcc} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [3:0]          opc_q, opc_d;
  logic [VEC_W-1:0]    op1_q, op1_d;
  logic [VEC_W-1:0]    op2_q, op2_d;
  logic [LaneBits-1:0] lane_q, lane_d;
  logic [LANE_W-1:0]   acc_q, acc_d;
  logic [VEC_W-1:0]    result_q, result_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                fu_req_q, fu_req_d;
  logic                fu_op_q, fu_op_d;
  logic [LANE_W-1:0]   fu_a_q, fu_a_d;
  logic [LANE_W-1:0]   fu_b_q, fu_b_d;

  logic [LaneBits-1:0] lane_nxt;
  logic [LANE_W-1:0]   a_nxt, b_nxt;

  function automatic logic [LANE_W-1:0] lane_of(input logic [VEC_W-1:0] v,
                                                 input logic [LaneBits-1:0] idx);
    return v[idx*LANE_W +: LANE_W];
  endfunction

  assign lane_nxt = lane_q + LaneBits'(1);
  assign a_nxt    = lane_of(op1_q, lane_nxt);
  assign b_nxt    = lane_of(op2_q, lane_nxt);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    opc_d       = opc_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    result_d    = result_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    fu_req_d    = fu_req_q;
    fu_op_d     = fu_op_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          opc_d      = opcode;
          op1_d      = op_1;
          op2_d      = op_2;
          result_d   = '0;
          lane_d     = '0;
          phase_d    = PhMul;
          acc_d      = '0;
          in_ready_d = 1'b0;
          case (opcode)
            OpVadd, OpVdot, OpSmul: begin
              // Lane 0 operands come straight from the ports so the FU starts next cycle.
              state_d  = StReq;
              fu_req_d = 1'b1;
              fu_op_d  = (opcode != OpVadd);
              fu_a_d   = op_1[LANE_W-1:0];
              fu_b_d   = op_2[LANE_W-1:0];
            end
            OpNop: begin
              state_d     = StDone;
              out_valid_d = 1'b1;
              err_d       = 1'b0;
            end
            default: begin
              state_d     = StDone;
              out_valid_d = 1'b1;
              err_d       = 1'b1;
            end
          endcase
        end
      end

      StReq: begin
        if (fu_ack) begin
          if (opc_q == OpVdot) begin
            if (lane_q == '0) begin
              acc_d   = fu_result;
              lane_d  = lane_nxt;
              fu_op_d = 1'b1;
              fu_a_d  = a_nxt;
              fu_b_d  = b_nxt;
            end else if (phase_q == PhMul) begin
              // fu_b_q doubles as the product holding register for the accumulate step.
              phase_d = PhAcc;
              fu_op_d = 1'b0;
              fu_a_d  = acc_q;
              fu_b_d  = fu_result;
            end else begin
              acc_d   = fu_result;
              phase_d = PhMul;
              if (lane_q == LastLane) begin
                result_d               = '0;
                result_d[LANE_W-1:0]   = fu_result;
                state_d                = StDone;
                fu_req_d               = 1'b0;
                out_valid_d            = 1'b1;
                err_d                  = 1'b0;
              end else begin
                lane_d  = lane_nxt;
                fu_op_d = 1'b1;
                fu_a_d  = a_nxt;
                fu_b_d  = b_nxt;
              end
            end
          end else begin
            result_d[lane_q*LANE_W +: LANE_W] = fu_result;
            if (lane_q == LastLane) begin
              state_d     = StDone;
              fu_req_d    = 1'b0;
              out_valid_d = 1'b1;
              err_d       = 1'b0;
            end else begin
              lane_d = lane_nxt;
              fu_a_d = (opc_q == OpSmul) ? op1_q[LANE_W-1:0] : a_nxt;
              fu_b_d = b_nxt;
            end
          end
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          err_d       = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        fu_req_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= PhMul;
      opc_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      fu_req_q    <= 1'b0;
      fu_op_q     <= 1'b0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      opc_q       <= opc_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      fu_req_q    <= fu_req_d;
      fu_op_q     <= fu_op_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign fu_req    = fu_req_q;
  assign fu_op     = fu_op_q;
  assign fu_a      = fu_a_q;
  assign fu_b      = fu_b_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Bench for vec_alu_sequencer: an integer-valued FP16 functional-unit model with random
// ack latency, plus a reference model computing results and FU traces from the op rules.
module tb_vec_alu_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'h0;
  logic [255:0] op_1 = '0;
  logic [255:0] op_2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] result;
  logic         err;
  logic         fu_req;
  logic         fu_op;
  logic [15:0]  fu_a;
  logic [15:0]  fu_b;
  logic         fu_ack = 1'b0;
  logic [15:0]  fu_result = '0;

  vec_alu_sequencer #(.LANES(16), .LANE_W(16), .VEC_W(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .op_1(op_1), .op_2(op_2), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .err(err), .fu_req(fu_req), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_ack(fu_ack),
    .fu_result(fu_result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Positive integer-valued FP16 encode/decode (values kept below 2048).
  function automatic int h2i(input logic [15:0] h);
    int e = int'(h[14:10]);
    int m = int'({1'b1, h[9:0]});
    if (e < 15 || e > 25) return 0;
    return m >>> (25 - e);
  endfunction

  function automatic logic [15:0] i2h(input int n);
    int p = 0;
    logic [15:0] h;
    if (n <= 0) return 16'h0000;
    if (n >= 2048) return 16'h7C00;
    while ((n >> (p + 1)) != 0) p++;
    h = '0;
    h[14:10] = 5'(p + 15);
    h[9:0]   = 10'((n << (10 - p)) & 1023);
    return h;
  endfunction

  function automatic logic [15:0] fu_calc(input logic op, input logic [15:0] a, input logic [15:0] b);
    int ia = h2i(a);
    int ib = h2i(b);
    return i2h(op ? ia * ib : ia + ib);
  endfunction

  // FU model: takes each request, acks after a random 1..N cycle latency.
  int          lat_min = 1;
  int          lat_max = 1;
  bit          busy = 1'b0;
  int          wait_left = 0;
  logic [32:0] fu_cap;
  logic [32:0] fu_log[$];
  int          stab_viol = 0;

  always @(negedge clk) begin
    fu_ack = 1'b0;
    if (!rst_n || !fu_req) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy      = 1'b1;
        wait_left = int'($urandom_range(lat_max, lat_min)) - 1;
        fu_cap    = {fu_op, fu_a, fu_b};
      end else begin
        if ({fu_op, fu_a, fu_b} !== fu_cap) stab_viol++;
        if (wait_left > 0) wait_left--;
      end
      if (wait_left == 0) begin
        fu_ack    = 1'b1;
        fu_result = fu_calc(fu_op, fu_a, fu_b);
        fu_log.push_back({fu_op, fu_a, fu_b});
        busy      = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int           va[16];
  int           vb[16];
  logic [255:0] vec_a;
  logic [255:0] vec_b;
  logic [255:0] exp_res;
  logic [32:0]  exp_tr[$];

  task automatic set_vecs(input int amax);
    for (int i = 0; i < 16; i++) begin
      va[i] = (amax < 0) ? -amax : int'($urandom_range(amax, 0));
      vb[i] = (amax < 0) ? -amax : int'($urandom_range(amax, 0));
      vec_a[i*16 +: 16] = i2h(va[i]);
      vec_b[i*16 +: 16] = i2h(vb[i]);
    end
  endtask

  // Reference: expected result vector and FU transaction sequence.
  task automatic model(input logic [3:0] opc);
    int acc;
    int p;
    exp_res = '0;
    exp_tr.delete();
    case (opc)
      4'h0: for (int i = 0; i < 16; i++) begin
        exp_res[i*16 +: 16] = i2h(va[i] + vb[i]);
        exp_tr.push_back({1'b0, i2h(va[i]), i2h(vb[i])});
      end
      4'h2: for (int i = 0; i < 16; i++) begin
        exp_res[i*16 +: 16] = i2h(va[0] * vb[i]);
        exp_tr.push_back({1'b1, i2h(va[0]), i2h(vb[i])});
      end
      4'h1: begin
        acc = va[0] * vb[0];
        exp_tr.push_back({1'b1, i2h(va[0]), i2h(vb[0])});
        for (int i = 1; i < 16; i++) begin
          p = va[i] * vb[i];
          exp_tr.push_back({1'b1, i2h(va[i]), i2h(vb[i])});
          exp_tr.push_back({1'b0, i2h(acc), i2h(p)});
          acc += p;
        end
        exp_res[15:0] = i2h(acc);
      end
      default: ;
    endcase
  endtask

  task automatic start_op(input logic [3:0] opc, input logic [255:0] a, input logic [255:0] b);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = opc;
    op_1     = a;
    op_2     = b;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk);
    fu_log.delete();
    stab_viol = 0;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 3000);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, "_hs_out_valid"}, out_valid, 1'b0);
    check({name, "_hs_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic run_check(input string name, input logic [3:0] opc, input int exp_lat);
    int lat;
    model(opc);
    start_op(opc, vec_a, vec_b);
    wait_done(lat);
    check({name, "_out_valid"}, out_valid, 1'b1);
    if (exp_lat > 0) check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, result, exp_res);
    check({name, "_err"}, err, (opc > 4'h2 && opc != 4'hF));
    check({name, "_trace_len"}, fu_log.size(), exp_tr.size());
    for (int i = 0; i < exp_tr.size() && i < fu_log.size(); i++)
      check($sformatf("%s_trace%0d", name, i), fu_log[i], exp_tr[i]);
    check({name, "_fu_stable"}, stab_viol, 0);
    handshake(name);
  endtask

  initial begin
    int g;
    int lat;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_fu_req", fu_req, 1'b0);
    check("rst_fu_op", fu_op, 1'b0);
    check("rst_fu_a", fu_a, 16'h0);
    check("rst_fu_b", fu_b, 16'h0);
    check("rst_result", result, 256'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    set_vecs(-1);
    check("vadd_ones_vec", vec_a[31:0], 32'h3C00_3C00);
    run_check("vadd_ones", 4'h0, 17);
    run_check("vdot_ones", 4'h1, 32);

    set_vecs(-1);
    va[0] = 2;
    vec_a[15:0] = 16'h4000;
    vec_a[255:16] = {15{16'hFFFF}};
    run_check("smul", 4'h2, 17);

    vec_a = {16{$urandom()}};
    run_check("nop", 4'hF, 1);
    run_check("unsup", 4'b0110, 1);

    // Result held under backpressure; a waiting instruction is not taken early.
    set_vecs(7);
    model(4'h0);
    start_op(4'h0, vec_a, vec_b);
    wait_done(lat);
    check("bp_done", out_valid, 1'b1);
    in_valid = 1'b1;
    opcode   = 4'hF;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_result", result, exp_res);
      check("bp_err", err, 1'b0);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_out_valid", out_valid, 1'b0);
    check("bp_idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_nop_out_valid", out_valid, 1'b1);
    check("bp_nop_result", result, 256'h0);
    check("bp_nop_err", err, 1'b0);
    handshake("bp_nop");

    lat_min = 1;
    lat_max = 6;
    set_vecs(-1);
    run_check("vdot_slow_ones", 4'h1, 0);
    for (int k = 0; k < 6; k++) begin
      set_vecs(7);
      run_check($sformatf("rnd%0d", k), 4'($urandom_range(2, 0)), 0);
    end

    // Reset while VDOT is working on lane 7.
    set_vecs(7);
    start_op(4'h1, vec_a, vec_b);
    g = 0;
    while (fu_log.size() < 13 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("rst_mid_reached_lane7", fu_log.size() >= 13, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_fu_req", fu_req, 1'b0);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    lat_min = 1;
    lat_max = 1;
    set_vecs(7);
    run_check("vadd_after_rst", 4'h0, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
